// File: rtl/reg_file_dump_reader_pkg.sv
// Shared types and constants for the register-file dump engine.
// Holds the FSM state encoding and the architectural register-file constants.
package reg_file_dump_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    localparam int          REG_COUNT      = 32;
    localparam logic [31:0] SP_RESET_VALUE = 32'h0000_0400;

endpackage

// File: rtl/reg_file_dump_reader.sv
// Walks register-file read port 2 from FIRST_REG to LAST_REG and streams {index, value} beats.
// Latency: 2 cycles per beat (READ capture, then SEND); done_o 1 cycle after the last accept.
// Backpressure: a beat is held stable in SEND until out_ready_i; only abort_i may withdraw it.
module reg_file_dump_reader
    import reg_file_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  stall_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_index_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);

    dump_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] out_index_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= FIRST_IDX;
            out_index_q <= FIRST_IDX;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                out_index_q <= idx_q;
                out_data_q  <= rd_data_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = FIRST_IDX;
                if (start_i) state_d = ST_READ;
            end
            ST_READ: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = FIRST_IDX;
                end else begin
                    capture = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = FIRST_IDX;
                end else if (out_ready_i) begin
                    // Terminating on the compare keeps idx from ever stepping past LAST_REG.
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = FIRST_IDX;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = FIRST_IDX;
            end
        endcase
    end

    assign rd_addr_o   = idx_q;
    assign stall_o     = (state_q != ST_IDLE);
    assign out_valid_o = (state_q == ST_SEND);
    assign out_index_o = out_index_q;
    assign out_data_o  = out_data_q;
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign done_o      = (state_q == ST_DONE) && !abort_i;

endmodule
